// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-stream side and framed-payload side of the UART frame controller.
// The slave modport is the controller; the master modport is the UART/sink side.
interface uart_rx_frame_ctrl_if;
  logic [7:0] In_data;
  logic       In_data_vld;
  logic       In_ready;
  logic [7:0] Out_data;
  logic       Out_data_vld;
  logic       Out_last;
  logic [4:0] Out_len;
  logic       Out_err;
  logic [1:0] Out_err_code;
  logic       Out_drop;
  logic       Out_busy;

  modport master (
    output In_data, In_data_vld, In_ready,
    input  Out_data, Out_data_vld, Out_last, Out_len,
    input  Out_err, Out_err_code, Out_drop, Out_busy
  );

  modport slave (
    input  In_data, In_data_vld, In_ready,
    output Out_data, Out_data_vld, Out_last, Out_len,
    output Out_err, Out_err_code, Out_drop, Out_busy
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Parses HEADER/LEN/payload/CHK frames from a UART byte stream, buffers the payload
// and replays it downstream with a valid/ready handshake.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                 Clk,
  input  logic                 Rst,
  uart_rx_frame_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_SEND} state_t;

  localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_LEN = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  state_t           state, state_nxt;
  logic [4:0]       len, wr_idx, rd_idx;
  logic [7:0]       chk;
  logic [CNT_W-1:0] tmo_cnt;
  logic [7:0]       pay_mem [32];
  logic             err_q, drop_q;
  logic [1:0]       err_code_q;

  logic             vld, tmo_on, tmo_hit, len_bad, chk_ok, wr_last, rd_last;
  logic             err_set, drop_set;
  logic [1:0]       err_code_set;
  logic [7:0]       out_data;
  logic             out_vld, out_last;
  logic [4:0]       out_len;

  assign vld     = bus.In_data_vld;
  assign tmo_on  = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  // A strobe in the terminal-count cycle wins over the timeout.
  assign tmo_hit = tmo_on && !vld && (tmo_cnt == CNT_LAST);
  assign len_bad = (bus.In_data == 8'd0) || (bus.In_data > MAX_LEN_B);
  assign chk_ok  = (bus.In_data == chk);
  assign wr_last = (wr_idx == len - 5'd1);
  assign rd_last = (rd_idx == len - 5'd1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaulting every comb output first keeps this block free of inferred latches.
    state_nxt = state;
    unique case (state)
      S_IDLE: if (vld && bus.In_data == HEADER) state_nxt = S_LEN;
      S_LEN: begin
        if (vld)          state_nxt = len_bad ? S_IDLE : S_DATA;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_DATA: begin
        if (vld) begin
          if (wr_last) state_nxt = S_CHK;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_CHK: begin
        if (vld)          state_nxt = chk_ok ? S_SEND : S_IDLE;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_SEND: if (bus.In_ready && rd_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    err_set      = 1'b0;
    err_code_set = 2'b00;
    drop_set     = 1'b0;
    out_vld      = 1'b0;
    out_data     = 8'h00;
    out_last     = 1'b0;
    out_len      = 5'd0;
    unique case (state)
      S_LEN: begin
        if (vld && len_bad) begin err_set = 1'b1; err_code_set = ERR_LEN; end
        else if (tmo_hit)   begin err_set = 1'b1; err_code_set = ERR_TMO; end
      end
      S_DATA: begin
        if (tmo_hit) begin err_set = 1'b1; err_code_set = ERR_TMO; end
      end
      S_CHK: begin
        if (vld && !chk_ok) begin err_set = 1'b1; err_code_set = ERR_CHK; end
        else if (tmo_hit)   begin err_set = 1'b1; err_code_set = ERR_TMO; end
      end
      S_SEND: begin
        out_vld  = 1'b1;
        out_data = pay_mem[rd_idx];
        out_last = rd_last;
        out_len  = len;
        drop_set = vld;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      len        <= 5'd0;
      chk        <= 8'h00;
      wr_idx     <= 5'd0;
      rd_idx     <= 5'd0;
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      drop_q     <= 1'b0;
    end else begin
      err_q  <= err_set;
      drop_q <= drop_set;
      if (err_set) err_code_q <= err_code_set;

      if (!tmo_on || vld || state_nxt != state) tmo_cnt <= '0;
      else                                      tmo_cnt <= tmo_cnt + CNT_W'(1);

      unique case (state)
        S_LEN: if (vld && !len_bad) begin
          len    <= bus.In_data[4:0];
          chk    <= bus.In_data;
          wr_idx <= 5'd0;
        end
        S_DATA: if (vld) begin
          chk    <= chk ^ bus.In_data;
          wr_idx <= wr_idx + 5'd1;
        end
        S_CHK:  if (vld) rd_idx <= 5'd0;
        S_SEND: if (bus.In_ready) rd_idx <= rd_idx + 5'd1;
        default: ;
      endcase
    end
  end

  // NOTE: the payload memory is deliberately not reset; a slot is only read after DATA wrote it.
  always_ff @(posedge Clk) begin
    if (state == S_DATA && vld) pay_mem[wr_idx] <= bus.In_data;
  end

  assign bus.Out_data     = out_data;
  assign bus.Out_data_vld = out_vld;
  assign bus.Out_last     = out_last;
  assign bus.Out_len      = out_len;
  assign bus.Out_err      = err_q;
  assign bus.Out_err_code = err_code_q;
  assign bus.Out_drop     = drop_q;
  assign bus.Out_busy     = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed and randomized checks of uart_rx_frame_ctrl against a byte-stream frame parser model.
module tb_uart_rx_frame_ctrl;
  localparam logic [7:0] HDR  = 8'hA5;
  localparam int         MAXL = 16;
  localparam int         TMO  = 100;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  uart_rx_frame_ctrl_if bus ();

  uart_rx_frame_ctrl #(.HEADER(HDR), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int err_cnt  = 0;
  int drop_cnt = 0;
  int vld_cnt  = 0;

  // Output entries are packed as {len[4:0], last, data[7:0]}.
  logic [13:0] obs_out[$];
  logic [13:0] exp_out[$];
  logic [1:0]  obs_err[$];
  logic [1:0]  exp_err[$];
  logic [7:0]  stim[$];

  logic       hold_pend = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Monitor: records accepted bytes, error pulses and drops; checks hold while stalled.
  always @(negedge Clk) begin
    if (Rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_vld",  bus.Out_data_vld, 1);
        check("hold_data", bus.Out_data, hold_data);
        check("hold_last", bus.Out_last, hold_last);
      end
      hold_pend = bus.Out_data_vld && !bus.In_ready;
      hold_data = bus.Out_data;
      hold_last = bus.Out_last;
      if (bus.Out_data_vld) vld_cnt++;
      if (bus.Out_data_vld && bus.In_ready)
        obs_out.push_back({bus.Out_len, bus.Out_last, bus.Out_data});
      if (bus.Out_err) begin
        err_cnt++;
        obs_err.push_back(bus.Out_err_code);
      end
      if (bus.Out_drop) drop_cnt++;
    end
  end

  // Reference parser: walks the byte stream by frame arithmetic and lists expected results.
  function automatic void predict();
    int i = 0;
    int l;
    logic [7:0] x;
    while (i < stim.size()) begin
      if (stim[i] != HDR) begin i++; continue; end
      if (i + 1 >= stim.size()) break;
      l = int'(stim[i+1]);
      if (l == 0 || l > MAXL) begin
        exp_err.push_back(2'b10);
        i += 2;
        continue;
      end
      if (i + 2 + l >= stim.size()) break;
      x = stim[i+1];
      for (int k = 0; k < l; k++) x ^= stim[i+2+k];
      if (stim[i+2+l] == x) begin
        for (int k = 0; k < l; k++) exp_out.push_back({5'(l), k == l - 1, stim[i+2+k]});
      end else begin
        exp_err.push_back(2'b01);
      end
      i += l + 3;
    end
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic strobe(input logic [7:0] b);
    bus.In_data     = b;
    bus.In_data_vld = 1'b1;
    @(posedge Clk); #1;
    bus.In_data_vld = 1'b0;
    bus.In_data     = 8'h00;
  endtask

  task automatic send_stim(input int max_gap, input bit rnd_ready);
    foreach (stim[i]) begin
      strobe(stim[i]);
      repeat ($urandom_range(0, max_gap)) begin
        if (rnd_ready) bus.In_ready = 1'($urandom_range(0, 1));
        @(posedge Clk); #1;
      end
    end
  endtask

  task automatic wait_idle(input int budget, input bit rnd_ready);
    int k = 0;
    while (bus.Out_busy && k < budget) begin
      if (rnd_ready) bus.In_ready = 1'($urandom_range(0, 1));
      @(posedge Clk); #1;
      k++;
    end
    check("wait_idle", bus.Out_busy, 0);
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_nout"}, obs_out.size(), exp_out.size());
    for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++)
      check({tag, "_out"}, obs_out[i], exp_out[i]);
    check({tag, "_nerr"}, obs_err.size(), exp_err.size());
    for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++)
      check({tag, "_err"}, obs_err[i], exp_err[i]);
    obs_out.delete(); exp_out.delete(); obs_err.delete(); exp_err.delete();
  endtask

  task automatic add_checked_frame(input logic [7:0] l, input logic [7:0] payload[$], input logic [7:0] chk_flip);
    logic [7:0] x = l;
    stim.push_back(HDR);
    stim.push_back(l);
    foreach (payload[i]) begin
      stim.push_back(payload[i]);
      x ^= payload[i];
    end
    stim.push_back(x ^ chk_flip);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e0, v0, d0, first, l;
    logic [7:0] pl[$];

    bus.In_data = 8'h00; bus.In_data_vld = 1'b0; bus.In_ready = 1'b0;
    #12;
    check("rst_vld",  bus.Out_data_vld, 0);
    check("rst_data", bus.Out_data, 0);
    check("rst_last", bus.Out_last, 0);
    check("rst_len",  bus.Out_len, 0);
    check("rst_err",  bus.Out_err, 0);
    check("rst_code", bus.Out_err_code, 0);
    check("rst_drop", bus.Out_drop, 0);
    check("rst_busy", bus.Out_busy, 0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    cycles(2);

    // Good 3-byte frame, streamed with In_ready held high.
    bus.In_ready = 1'b1;
    e0 = err_cnt;
    strobe(8'hA5); strobe(8'h03); strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h03);
    check("f1_vld0", bus.Out_data_vld, 1);
    check("f1_d0",   bus.Out_data, 8'h11);
    check("f1_l0",   bus.Out_last, 0);
    check("f1_len",  bus.Out_len, 3);
    cycles(1);
    check("f1_d1",   bus.Out_data, 8'h22);
    check("f1_l1",   bus.Out_last, 0);
    cycles(1);
    check("f1_d2",   bus.Out_data, 8'h33);
    check("f1_l2",   bus.Out_last, 1);
    check("f1_len2", bus.Out_len, 3);
    cycles(1);
    check("f1_vld_end", bus.Out_data_vld, 0);
    check("f1_busy_end", bus.Out_busy, 0);
    check("f1_noerr", err_cnt - e0, 0);

    // Checksum mismatch.
    e0 = err_cnt; v0 = vld_cnt;
    strobe(8'hA5); strobe(8'h03); strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h04);
    check("chk_err",  bus.Out_err, 1);
    check("chk_code", bus.Out_err_code, 2'b01);
    check("chk_busy", bus.Out_busy, 0);
    cycles(1);
    check("chk_pulse", bus.Out_err, 0);
    cycles(3);
    check("chk_code_held", bus.Out_err_code, 2'b01);
    check("chk_nerr", err_cnt - e0, 1);
    check("chk_novld", vld_cnt - v0, 0);

    // Bad lengths, then a one-byte frame whose payload equals HEADER.
    e0 = err_cnt;
    strobe(8'hA5); strobe(8'h00);
    check("len0_err",  bus.Out_err, 1);
    check("len0_code", bus.Out_err_code, 2'b10);
    check("len0_busy", bus.Out_busy, 0);
    strobe(8'hA5); strobe(8'h11);
    check("len17_err",  bus.Out_err, 1);
    check("len17_code", bus.Out_err_code, 2'b10);
    strobe(8'hA5); strobe(8'h01); strobe(8'hA5); strobe(8'hA4);
    check("f2_vld",  bus.Out_data_vld, 1);
    check("f2_data", bus.Out_data, 8'hA5);
    check("f2_last", bus.Out_last, 1);
    check("f2_len",  bus.Out_len, 1);
    cycles(1);
    check("f2_vld_end", bus.Out_data_vld, 0);
    check("len_nerr", err_cnt - e0, 2);

    // Strobe landing exactly on the timeout terminal-count cycle wins.
    e0 = err_cnt;
    strobe(8'hA5);
    cycles(TMO - 1);
    strobe(8'h01); strobe(8'h5C); strobe(8'h5D);
    check("race_vld",  bus.Out_data_vld, 1);
    check("race_data", bus.Out_data, 8'h5C);
    check("race_noerr", err_cnt - e0, 0);
    cycles(1);

    // Silence after a partial payload times out TMO cycles after the last strobe.
    e0 = err_cnt; first = -1;
    strobe(8'hA5); strobe(8'h02); strobe(8'h7E);
    for (int k = 1; k <= TMO + 10; k++) begin
      @(posedge Clk); #1;
      if (first < 0 && bus.Out_err) first = k;
    end
    check("tmo_latency", first, TMO);
    check("tmo_code", bus.Out_err_code, 2'b11);
    check("tmo_busy", bus.Out_busy, 0);
    check("tmo_nerr", err_cnt - e0, 1);

    // 4-byte frame drained with In_ready toggling and a stray strobe during SEND.
    obs_out.delete(); obs_err.delete();
    d0 = drop_cnt;
    bus.In_ready = 1'b0;
    stim.delete();
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    add_checked_frame(8'h04, pl, 8'h00);
    predict();
    send_stim(0, 1'b0);
    check("stall_vld", bus.Out_data_vld, 1);
    for (int c = 0; c < 40 && bus.Out_busy; c++) begin
      bus.In_ready    = (c % 2 == 1);
      bus.In_data_vld = (c == 2);
      bus.In_data     = (c == 2) ? 8'h55 : 8'h00;
      @(posedge Clk); #1;
    end
    bus.In_data_vld = 1'b0;
    check("stall_busy", bus.Out_busy, 0);
    cycles(1);
    compare_queues("stall");
    check("stall_drops", drop_cnt - d0, 1);

    // Reset mid-payload abandons the frame silently; the next frame is clean.
    bus.In_ready = 1'b1;
    e0 = err_cnt;
    strobe(8'hA5); strobe(8'h03); strobe(8'h11);
    check("mrst_busy_pre", bus.Out_busy, 1);
    #2 Rst = 1'b1;
    #1;
    check("mrst_busy", bus.Out_busy, 0);
    check("mrst_vld",  bus.Out_data_vld, 0);
    check("mrst_err",  bus.Out_err, 0);
    check("mrst_code", bus.Out_err_code, 0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    cycles(2);
    check("mrst_noerr", err_cnt - e0, 0);
    obs_out.delete(); obs_err.delete();
    stim.delete();
    pl = '{8'h66, 8'h77};
    add_checked_frame(8'h02, pl, 8'h00);
    predict();
    send_stim(0, 1'b0);
    wait_idle(20, 1'b0);
    cycles(1);
    compare_queues("mrst_frame");

    // Randomized bursts: junk, then a good, bad-checksum or bad-length frame.
    for (int b = 0; b < 24; b++) begin
      stim.delete();
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] j;
        do j = 8'($urandom); while (j == HDR);
        stim.push_back(j);
      end
      case ($urandom_range(0, 3))
        0, 1, 2: begin
          l = $urandom_range(1, MAXL);
          pl.delete();
          repeat (l) pl.push_back(8'($urandom));
          add_checked_frame(8'(l), pl, (b % 4 == 3) ? 8'($urandom_range(1, 255)) : 8'h00);
        end
        default: begin
          stim.push_back(HDR);
          stim.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
        end
      endcase
      predict();
      send_stim(3, 1'b1);
      wait_idle(200, 1'b1);
      cycles(1);
      compare_queues("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
